// File: rtl/eject_receiver_pkg.sv
// rtl/eject_receiver_pkg.sv - shared packet layout, op codes and FSM states
package eject_receiver_pkg;

  localparam int PKT_W = 85;

  // Router packet layout, MSB first: valid, comm, src, dst, op, seq, reserved, payload
  typedef struct packed {
    logic        valid;
    logic [7:0]  comm;
    logic [8:0]  src;
    logic [8:0]  dst;
    logic [3:0]  op;
    logic [5:0]  seq;
    logic [15:0] rsvd;
    logic [31:0] payload;
  } pkt_t;

  // Only the fields the collective logic needs are buffered
  typedef struct packed {
    logic [7:0]  comm;
    logic [3:0]  op;
    logic [31:0] payload;
  } entry_t;

  localparam logic [3:0] OP_BCAST   = 4'b0001;
  localparam logic [3:0] OP_BARRIER = 4'b0010;
  localparam logic [3:0] OP_REDUCE  = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/eject_receiver_if.sv
// rtl/eject_receiver_if.sv - router eject port: packet in, stall back
interface eject_receiver_if import eject_receiver_pkg::*; ;
  pkt_t in_eject;
  logic eject_stall;

  modport master (output in_eject, input eject_stall);
  modport slave  (input in_eject, output eject_stall);
endinterface

// File: rtl/eject_fifo.sv
// rtl/eject_fifo.sv - synchronous ingress FIFO with occupancy
module eject_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 44
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // A push into a full FIFO is only legal when the head leaves on the same edge
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone says which entries are live
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
endmodule

// File: rtl/eject_receiver.sv
// rtl/eject_receiver.sv - collective (broadcast/barrier/reduce) receiver at a router eject port
module eject_receiver import eject_receiver_pkg::*; #(
  parameter logic [8:0] NODE_ID    = 9'd0,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  eject_receiver_if.slave         eject,
  input  logic                    start,
  input  logic [7:0]              cfg_comm,
  input  logic [3:0]              cfg_op,
  input  logic [8:0]              cfg_count,
  output logic [31:0]             result,
  output logic                    result_valid,
  output logic                    busy,
  output logic [7:0]              drop_cnt,
  output logic                    overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [7:0]  r_cfg_comm;
  logic [3:0]  r_cfg_op;
  logic [8:0]  r_cfg_count;
  logic [8:0]  r_count;
  logic [31:0] r_acc;
  logic [7:0]  r_drop_cnt;
  logic        r_overflow;

  pkt_t        w_pkt;
  entry_t      w_wr_entry;
  entry_t      w_rd_entry;
  logic        w_dst_hit;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [CW-1:0] w_occ;
  logic        w_in_drop;
  logic        w_col_drop;
  logic        w_count_hit;
  logic        w_latch;
  logic [1:0]  w_drop_inc;
  logic [8:0]  w_drop_sum;
  logic        w_unused_fields;

  assign w_pkt           = eject.in_eject;
  assign w_unused_fields = ^{w_pkt.src, w_pkt.seq, w_pkt.rsvd};
  assign w_dst_hit       = w_pkt.valid && (w_pkt.dst == NODE_ID);
  assign w_push          = w_dst_hit && (!w_full || w_pop);
  assign w_in_drop       = w_pkt.valid && !w_push;
  assign w_wr_entry      = '{comm: w_pkt.comm, op: w_pkt.op, payload: w_pkt.payload};

  eject_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(entry_t))) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_wr_entry),
    .i_pop   (w_pop),
    .o_data  (w_rd_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_occ)
  );

  // Stall one entry early so a packet already in flight still finds room
  assign eject.eject_stall = (w_occ >= CW'(FIFO_DEPTH - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, pop decision and packet classification
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_latch      = 1'b0;
    w_count_hit  = 1'b0;
    w_col_drop   = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_latch     = 1'b1;
          w_state_nxt = (cfg_count == 9'd0) ? ST_DONE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        // Completion is judged on the registered count, so nothing is popped once it is reached
        if (r_count == r_cfg_count) begin
          w_state_nxt = ST_DONE;
        end else if (!w_empty) begin
          w_pop = 1'b1;
          if (w_rd_entry.comm == r_cfg_comm && w_rd_entry.op == r_cfg_op) w_count_hit = 1'b1;
          else                                                           w_col_drop  = 1'b1;
        end
      end
      ST_DONE: begin
        result_valid = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Collective configuration, contribution counter and accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_comm  <= '0;
      r_cfg_op    <= '0;
      r_cfg_count <= '0;
      r_count     <= '0;
      r_acc       <= '0;
    end else if (w_latch) begin
      r_cfg_comm  <= cfg_comm;
      r_cfg_op    <= cfg_op;
      r_cfg_count <= cfg_count;
      r_count     <= '0;
      r_acc       <= '0;
    end else if (w_count_hit) begin
      r_count <= r_count + 9'd1;
      if (r_cfg_op == OP_REDUCE)     r_acc <= r_acc + w_rd_entry.payload;
      else if (r_cfg_op == OP_BCAST) r_acc <= w_rd_entry.payload;
    end
  end

  // Ingress and collect-side drops can land on the same edge, so add up to two and saturate
  assign w_drop_inc = {1'b0, w_in_drop} + {1'b0, w_col_drop};
  assign w_drop_sum = {1'b0, r_drop_cnt} + {7'd0, w_drop_inc};

  // Drop counter and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      if (w_dst_hit && !w_push) r_overflow <= 1'b1;
    end
  end

  assign result   = r_acc;
  assign drop_cnt = r_drop_cnt;
  assign overflow = r_overflow;
endmodule

// File: doc/eject_receiver.md
EJECT_RECEIVER -- requirements
Module: eject_receiver

Interface
REQ-001 Parameter NODE_ID, default 9'd0, this node's 3x3-bit coordinate; ejected packets with a different dst are dropped.
REQ-002 Parameter FIFO_DEPTH, default 4, ingress buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_eject  input  85  ejected packet from router eject port; bit 84 = packet valid.
REQ-006 eject_stall  output  1  backpressure to router eject port.
REQ-007 start  input  1  one-cycle pulse arming a collective.
REQ-008 cfg_comm  input  8  communicator ID to accept, sampled on start.
REQ-009 cfg_op  input  4  expected op: 4'b0001 broadcast, 4'b0010 barrier, 4'b0011 reduce-sum; sampled on start.
REQ-010 cfg_count  input  9  number of contributions to collect, sampled on start.
REQ-011 result  output  32  reduce sum / broadcast payload / 0 for barrier.
REQ-012 result_valid  output  1  one-cycle completion pulse.
REQ-013 busy  output  1  high in COLLECT and DONE.
REQ-014 drop_cnt  output  8  saturating count of dropped packets.
REQ-015 overflow  output  1  sticky: valid packet arrived with FIFO full.

Function
REQ-016 Packet fields: [84] valid, [83:76] comm, [75:67] src, [66:58] dst, [57:54] op, [53:48] seq, [47:32] reserved, [31:0] payload.
REQ-017 Valid packet with dst==NODE_ID and FIFO not full is written into the FIFO on the same edge; dst mismatch -> dropped, drop_cnt+1.
REQ-018 Valid packet arriving with FIFO full -> discarded, overflow set, drop_cnt+1; simultaneous push and pop when full accepts the packet.
REQ-019 eject_stall = 1 whenever FIFO occupancy >= FIFO_DEPTH-1 (registered-free, combinational from occupancy).
REQ-020 FSM states IDLE, COLLECT, DONE; IDLE after reset.
REQ-021 IDLE: FIFO not popped; start latches cfg_*, clears accumulator and counter; cfg_count==0 -> DONE, else COLLECT.
REQ-022 COLLECT: pop one entry per cycle when non-empty; comm==cfg_comm and op==cfg_op -> counted, else dropped (drop_cnt+1).
REQ-023 Reduce-sum: accumulator += payload modulo 2^32 (wrap, no flag); broadcast: accumulator = payload of last counted packet; barrier: accumulator stays 0.
REQ-024 When the counted packet makes count == cfg_count, next state DONE.
REQ-025 DONE lasts exactly one cycle: result_valid=1, result=accumulator; then IDLE; result holds value until next start.
REQ-026 start while busy is ignored.
REQ-027 Latency: packet written at edge N is earliest popped/counted at edge N+1; if it completes the count, result_valid is high in the cycle after edge N+2.
REQ-028 drop_cnt saturates at 8'hFF; overflow cleared only by reset.

Reset
REQ-029 rst asserted (any time, including mid-COLLECT) -> state IDLE, FIFO empty, accumulator/count/result 0, result_valid 0, busy 0, drop_cnt 0, overflow 0, eject_stall 0.
REQ-030 Packets presented during reset are discarded and not counted.

Structure
REQ-031 Packet field offsets/widths, op encodings and FSM state encodings live in a shared package used by injection and ejection logic.
REQ-032 Ingress buffer is a separate sub-module eject_fifo (synchronous, DEPTH entries, full/empty/occupancy outputs).
REQ-033 Total RTL 120-400 lines; no multi-cycle paths.

Verification
REQ-034 Start comm=0x00, op=0011, count=3; eject payloads 5,7,9 to NODE_ID on consecutive cycles -> result=21, result_valid one pulse, drop_cnt=0.
REQ-035 Reduce-sum count=2, payloads 0xFFFF_FFFF and 0x2 -> result=0x0000_0001.
REQ-036 Start comm=0x01, count=1; eject comm=0x02 then comm=0x01 payload 0xAB op=0001 (cfg_op=0001) -> drop_cnt=1, result=0xAB.
REQ-037 While IDLE, eject 5 valid packets back-to-back (DEPTH=4) -> eject_stall high after 3rd, 5th packet dropped, overflow=1, drop_cnt=1.
REQ-038 Barrier count=0 -> result_valid in cycle after start, result=0; then assert rst mid-collective of a second count=4 run -> all outputs return to reset values, next start runs normally.
